cu_fetch_exec: RTL and testbench

Memory-based control unit for the bus processor. It fetches each instruction from synchronous memory through the R7 program counter, loads it into IR, and sequences the register file, A/G adder, address and data-out registers to execute it. It replaces the DIN-fed control FSM when the processor is attached to on-chip RAM, and drives the same bus-select and load-enable signals plus memory-side enables.

---
 rtl/cu_pkg.sv | 31 +++
 rtl/cu_fetch_exec_if.sv | 46 ++++
 rtl/dec3to8.sv | 14 +
 rtl/cu_fetch_exec.sv | 198 +++++++++++++++++++
 tb/tb_cu_fetch_exec.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// cu_pkg
// Shared constants for the memory-based control unit: the 3-bit state
// encoding (IDLE=000, then F1..F3 and E1..E3 in order), the 3-bit opcode
// map held in IR[8:6], and a small decode helper.
package cu_pkg;

  // State encoding, kept as plain constants so legacy code can compare raw bits
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_F1   = 3'd1;
  localparam logic [2:0] S_F2   = 3'd2;
  localparam logic [2:0] S_F3   = 3'd3;
  localparam logic [2:0] S_E1   = 3'd4;
  localparam logic [2:0] S_E2   = 3'd5;
  localparam logic [2:0] S_E3   = 3'd6;

  // Opcode map
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  // Opcodes whose execute phase runs all the way to E3
  function automatic logic has_e3(input logic [2:0] op);
    return (op == OP_MVI) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_LD);
  endfunction

endpackage

// File: rtl/cu_fetch_exec_if.sv
// cu_fetch_exec_if
// Control bundle between the control unit and the processor datapath.
//   Run     : start/continue request (datapath side -> control unit)
//   IR      : instruction register contents {I, X, Y}
//   GNZ     : G register non-zero flag
//   Done    : last cycle of the current instruction
//   Rin     : one-hot register load enables R0..R7
//   Rout    : one-hot register bus drive R0..R7
//   IRin, Ain, Gin : IR, A and G load enables
//   Gout, DINout   : G and memory data bus drive
//   AddSub  : 0 = add, 1 = subtract
//   ADDRin  : load address register from the bus
//   DOUTin  : load data-out register from the bus
//   W_D     : write-enable register input (memory write next cycle)
//   incr_pc : R7 increments at the end of this cycle
// master = control unit, slave = datapath.
interface cu_fetch_exec_if;
  logic       Run;
  logic [8:0] IR;
  logic       GNZ;
  logic       Done;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       IRin;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic       DINout;
  logic       AddSub;
  logic       ADDRin;
  logic       DOUTin;
  logic       W_D;
  logic       incr_pc;

  modport master (
    input  Run, IR, GNZ,
    output Done, Rin, Rout, IRin, Ain, Gin, Gout, DINout,
           AddSub, ADDRin, DOUTin, W_D, incr_pc
  );

  modport slave (
    output Run, IR, GNZ,
    input  Done, Rin, Rout, IRin, Ain, Gin, Gout, DINout,
           AddSub, ADDRin, DOUTin, W_D, incr_pc
  );
endinterface

// File: rtl/dec3to8.sv
// dec3to8
// 3-to-8 one-hot decoder with enable.
//   W  : 3-bit index
//   En : enable; all outputs 0 when low
//   Y  : one-hot output, Y[W] set when enabled
module dec3to8 (
  input  logic [2:0] W,
  input  logic       En,
  output logic [7:0] Y
);

  assign Y = En ? (8'd1 << W) : 8'd0;

endmodule

// File: rtl/cu_fetch_exec.sv
// cu_fetch_exec
// Memory-based control unit. Fetches each instruction through R7 from
// synchronous memory (F1: PC to address register, F2: read latency and PC
// increment, F3: load IR), then runs up to three execute cycles E1..E3
// decoded from the opcode. All outputs are combinational decodes of the
// current state and IR/GNZ.
//   Clock : system clock, rising-edge active
//   Reset : synchronous, active-high; returns to IDLE on the next edge
//   bus   : control bundle (master side), see cu_fetch_exec_if
module cu_fetch_exec
  import cu_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  cu_fetch_exec_if.master  bus
);

  logic [2:0] state;
  logic [2:0] next_state;
  logic [2:0] op;
  logic [7:0] x_dec;
  logic [7:0] y_dec;

  logic       done;
  logic [7:0] rin;
  logic [7:0] rout;
  logic       ir_in;
  logic       a_in;
  logic       g_in;
  logic       g_out;
  logic       din_out;
  logic       add_sub;
  logic       addr_in;
  logic       dout_in;
  logic       w_d;
  logic       incr_pc;

  assign op = bus.IR[8:6];

  dec3to8 u_dec_x (
    .W  (bus.IR[5:3]),
    .En (1'b1),
    .Y  (x_dec)
  );

  dec3to8 u_dec_y (
    .W  (bus.IR[2:0]),
    .En (1'b1),
    .Y  (y_dec)
  );

  // State register; reset wins over everything, abandoning any instruction
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: fetch is a fixed three-cycle walk, execute ends on Done,
  // and Run is only looked at in IDLE or on the Done cycle
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE: next_state = bus.Run ? S_F1 : S_IDLE;
      S_F1:   next_state = S_F2;
      S_F2:   next_state = S_F3;
      S_F3:   next_state = S_E1;
      S_E1: begin
        if (done) next_state = bus.Run ? S_F1 : S_IDLE;
        else      next_state = S_E2;
      end
      S_E2: begin
        if (done)            next_state = bus.Run ? S_F1 : S_IDLE;
        else if (has_e3(op)) next_state = S_E3;
        else                 next_state = S_IDLE;
      end
      S_E3: begin
        if (done) next_state = bus.Run ? S_F1 : S_IDLE;
        else      next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode; every enable defaults to 0 so IDLE and unused
  // state/opcode combinations drive nothing
  always_comb begin
    done    = 1'b0;
    rin     = 8'd0;
    rout    = 8'd0;
    ir_in   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    din_out = 1'b0;
    add_sub = 1'b0;
    addr_in = 1'b0;
    dout_in = 1'b0;
    w_d     = 1'b0;
    incr_pc = 1'b0;
    case (state)
      S_F1: begin
        rout    = 8'h80;
        addr_in = 1'b1;
      end
      S_F2: incr_pc = 1'b1;
      S_F3: begin
        din_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_E1: begin
        case (op)
          OP_MV: begin
            rout = y_dec;
            rin  = x_dec;
            done = 1'b1;
          end
          // Immediate operand is fetched like an instruction word
          OP_MVI: begin
            rout    = 8'h80;
            addr_in = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout = x_dec;
            a_in = 1'b1;
          end
          OP_LD, OP_ST: begin
            rout    = y_dec;
            addr_in = 1'b1;
          end
          // Conditional move: Done always, the transfer only when G != 0
          OP_MVNZ: begin
            done = 1'b1;
            if (bus.GNZ) begin
              rout = y_dec;
              rin  = x_dec;
            end
          end
          OP_RSVD: done = 1'b1;
        endcase
      end
      S_E2: begin
        case (op)
          OP_MVI: incr_pc = 1'b1;
          OP_ADD: begin
            rout = y_dec;
            g_in = 1'b1;
          end
          OP_SUB: begin
            rout    = y_dec;
            g_in    = 1'b1;
            add_sub = 1'b1;
          end
          OP_ST: begin
            rout    = x_dec;
            dout_in = 1'b1;
            w_d     = 1'b1;
            done    = 1'b1;
          end
          default: ;
        endcase
      end
      S_E3: begin
        case (op)
          OP_MVI, OP_LD: begin
            din_out = 1'b1;
            rin     = x_dec;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            g_out = 1'b1;
            rin   = x_dec;
            done  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.Done    = done;
  assign bus.Rin     = rin;
  assign bus.Rout    = rout;
  assign bus.IRin    = ir_in;
  assign bus.Ain     = a_in;
  assign bus.Gin     = g_in;
  assign bus.Gout    = g_out;
  assign bus.DINout  = din_out;
  assign bus.AddSub  = add_sub;
  assign bus.ADDRin  = addr_in;
  assign bus.DOUTin  = dout_in;
  assign bus.W_D     = w_d;
  assign bus.incr_pc = incr_pc;

endmodule

// File: tb/tb_cu_fetch_exec.sv
// tb_cu_fetch_exec
// Drives cu_fetch_exec with a small processor datapath and synchronous RAM
// built around it, and checks every control word against an instruction-level
// model that expands each fetched instruction into its cycle-by-cycle
// control words and updates architectural registers directly.
module tb_cu_fetch_exec;

  typedef logic [26:0] cw_t;

  // Control word layout: {Done, Rin[7:0], Rout[7:0], IRin, Ain, Gin, Gout,
  // DINout, AddSub, ADDRin, DOUTin, W_D, incr_pc}
  localparam cw_t C_DONE   = 27'h4000000;
  localparam cw_t C_IRIN   = 27'h0000200;
  localparam cw_t C_AIN    = 27'h0000100;
  localparam cw_t C_GIN    = 27'h0000080;
  localparam cw_t C_GOUT   = 27'h0000040;
  localparam cw_t C_DINOUT = 27'h0000020;
  localparam cw_t C_ADDSUB = 27'h0000010;
  localparam cw_t C_ADDRIN = 27'h0000008;
  localparam cw_t C_DOUTIN = 27'h0000004;
  localparam cw_t C_WD     = 27'h0000002;
  localparam cw_t C_INCR   = 27'h0000001;

  logic Clock;
  logic Reset;
  logic run_in;

  cu_fetch_exec_if bus ();

  cu_fetch_exec dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- datapath environment ----------------
  logic [8:0] prog [128];
  logic [8:0] mem [128];
  logic [8:0] r [8];
  logic [8:0] a_q, g_q, ir_q, addr_q, dout_q, mem_q, bus_val;
  logic       w_q;

  assign bus.Run = run_in;
  assign bus.IR  = ir_q;
  assign bus.GNZ = (g_q != 9'd0);

  always_comb begin
    bus_val = 9'd0;
    for (int i = 0; i < 8; i++) if (bus.Rout[i]) bus_val = r[i];
    if (bus.Gout)   bus_val = g_q;
    if (bus.DINout) bus_val = mem_q;
  end

  // Registers and RAM; the RAM is reloaded from prog whenever Reset is high
  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) r[i] <= 9'd0;
      for (int i = 0; i < 128; i++) mem[i] <= prog[i];
      a_q <= 9'd0; g_q <= 9'd0; ir_q <= 9'd0; addr_q <= 9'd0;
      dout_q <= 9'd0; w_q <= 1'b0; mem_q <= 9'd0;
    end else begin
      mem_q <= mem[addr_q[6:0]];
      if (bus.incr_pc) r[7] <= r[7] + 9'd1;
      for (int i = 0; i < 8; i++) if (bus.Rin[i]) r[i] <= bus_val;
      if (bus.Ain)    a_q    <= bus_val;
      if (bus.Gin)    g_q    <= bus.AddSub ? a_q - bus_val : a_q + bus_val;
      if (bus.IRin)   ir_q   <= bus_val;
      if (bus.ADDRin) addr_q <= bus_val;
      if (bus.DOUTin) dout_q <= bus_val;
      w_q <= bus.W_D;
      if (w_q) mem[addr_q[6:0]] <= dout_q;
    end
  end

  cw_t dut_word;
  assign dut_word = {bus.Done, bus.Rin, bus.Rout, bus.IRin, bus.Ain, bus.Gin,
                     bus.Gout, bus.DINout, bus.AddSub, bus.ADDRin, bus.DOUTin,
                     bus.W_D, bus.incr_pc};

  // ---------------- instruction-level model ----------------
  logic [8:0] m_r [8];
  logic [8:0] m_mem [128];
  logic [8:0] m_g;
  cw_t        exp_q [$];
  cw_t        cur_exp;
  bit         m_idle;
  bit         model_active = 1'b0;

  function automatic cw_t rout_w(input logic [7:0] v);
    return {9'd0, v, 10'd0};
  endfunction

  function automatic cw_t rin_w(input logic [7:0] v);
    return {1'b0, v, 18'd0};
  endfunction

  // Fetch the word at PC, push its full control sequence and apply its effect
  task automatic modelStartInstr();
    logic [8:0] iw, imm, res;
    logic [2:0] opc, x, y;
    logic [7:0] xo, yo;
    exp_q.push_back(rout_w(8'h80) | C_ADDRIN);
    exp_q.push_back(C_INCR);
    exp_q.push_back(C_DINOUT | C_IRIN);
    iw = m_mem[m_r[7][6:0]];
    m_r[7] = m_r[7] + 9'd1;
    opc = iw[8:6]; x = iw[5:3]; y = iw[2:0];
    xo = 8'd1 << x; yo = 8'd1 << y;
    case (opc)
      3'd0: begin
        exp_q.push_back(rout_w(yo) | rin_w(xo) | C_DONE);
        m_r[x] = m_r[y];
      end
      3'd1: begin
        exp_q.push_back(rout_w(8'h80) | C_ADDRIN);
        exp_q.push_back(C_INCR);
        exp_q.push_back(C_DINOUT | rin_w(xo) | C_DONE);
        imm = m_mem[m_r[7][6:0]];
        m_r[7] = m_r[7] + 9'd1;
        m_r[x] = imm;
      end
      3'd2, 3'd3: begin
        exp_q.push_back(rout_w(xo) | C_AIN);
        exp_q.push_back(rout_w(yo) | C_GIN | ((opc == 3'd3) ? C_ADDSUB : 27'd0));
        exp_q.push_back(C_GOUT | rin_w(xo) | C_DONE);
        res = (opc == 3'd3) ? m_r[x] - m_r[y] : m_r[x] + m_r[y];
        m_g = res;
        m_r[x] = res;
      end
      3'd4: begin
        exp_q.push_back(rout_w(yo) | C_ADDRIN);
        exp_q.push_back(27'd0);
        exp_q.push_back(C_DINOUT | rin_w(xo) | C_DONE);
        m_r[x] = m_mem[m_r[y][6:0]];
      end
      3'd5: begin
        exp_q.push_back(rout_w(yo) | C_ADDRIN);
        exp_q.push_back(rout_w(xo) | C_DOUTIN | C_WD | C_DONE);
        m_mem[m_r[y][6:0]] = m_r[x];
      end
      3'd6: begin
        if (m_g != 9'd0) begin
          exp_q.push_back(rout_w(yo) | rin_w(xo) | C_DONE);
          m_r[x] = m_r[y];
        end else begin
          exp_q.push_back(C_DONE);
        end
      end
      default: exp_q.push_back(C_DONE);
    endcase
  endtask

  initial begin
    forever begin
      @(posedge Clock);
      if (Reset) begin
        exp_q.delete();
        cur_exp = 27'd0;
        m_idle = 1'b1;
        model_active = 1'b1;
        for (int i = 0; i < 8; i++) m_r[i] = 9'd0;
        for (int i = 0; i < 128; i++) m_mem[i] = prog[i];
        m_g = 9'd0;
      end else if (model_active) begin
        if (m_idle || cur_exp[26]) begin
          if (run_in) begin
            modelStartInstr();
            cur_exp = exp_q.pop_front();
            m_idle = 1'b0;
          end else begin
            cur_exp = 27'd0;
            m_idle = 1'b1;
          end
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  bit watch_gout = 1'b0;
  int gout_seen = 0;

  initial begin
    forever begin
      @(negedge Clock);
      if (model_active) begin
        checkOutput($sformatf("ctrl_word@%0t", $time), 32'(dut_word), 32'(cur_exp));
        if (watch_gout && bus.Gout) gout_seen++;
      end
    end
  end

  task automatic applyStimulus(input bit rst, input bit rn, input int cycles);
    Reset  = rst;
    run_in = rn;
    repeat (cycles) @(negedge Clock);
  endtask

  // Drop Run, wait (bounded) for the current instruction's Done, then idle
  task automatic stopRun(input string tag);
    bit found = 1'b0;
    int k = 0;
    run_in = 1'b0;
    while (!found && k < 12) begin
      if (bus.Done) found = 1'b1;
      else begin
        @(negedge Clock);
        k++;
      end
    end
    checkOutput({tag, "_done_seen"}, 32'(found), 32'd1);
    repeat (3) @(negedge Clock);
    checkOutput({tag, "_idle_done"}, 32'(bus.Done), 32'd0);
  endtask

  logic [8:0] exp_r [8] = '{9'h014, 9'h00E, 9'h005, 9'h000,
                            9'h0AB, 9'h040, 9'h005, 9'h015};
  cw_t mvi_seq [6] = '{27'h0020008, 27'h0000001, 27'h0000220,
                       27'h0020008, 27'h0000001, 27'h4100020};

  initial begin
    for (int i = 0; i < 128; i++) prog[i] = 9'd0;
    prog[0]  = 9'h050; prog[1]  = 9'h005;   // mvi R2, 5
    prog[2]  = 9'h048; prog[3]  = 9'h00C;   // mvi R1, 12
    prog[4]  = 9'h058; prog[5]  = 9'h005;   // mvi R3, 5
    prog[6]  = 9'h068; prog[7]  = 9'h040;   // mvi R5, 0x40
    prog[8]  = 9'h060; prog[9]  = 9'h0AB;   // mvi R4, 0xAB
    prog[10] = 9'h0CB;                      // sub R1, R3
    prog[11] = 9'h165;                      // st  R4, [R5]
    prog[12] = 9'h135;                      // ld  R6, [R5]
    prog[13] = 9'h040; prog[14] = 9'h014;   // mvi R0, 20
    prog[15] = 9'h0DB;                      // sub R3, R3  (G = 0)
    prog[16] = 9'h1B8;                      // mvnz R7, R0 (not taken)
    prog[17] = 9'h1C0;                      // reserved
    prog[18] = 9'h089;                      // add R1, R1  (G = 14)
    prog[19] = 9'h1B8;                      // mvnz R7, R0 (taken -> 20)
    prog[20] = 9'h032;                      // mv  R6, R2
    prog[21] = 9'h078; prog[22] = 9'h015;   // mvi R7, 21 (spin)

    $display("[TB] reset and idle");
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("idle_done", 32'(bus.Done), 32'd0);
    checkOutput("idle_word", 32'(dut_word), 32'd0);

    $display("[TB] first instruction mvi R2");
    run_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      checkOutput($sformatf("mvi_cycle%0d", k), 32'(dut_word), 32'(mvi_seq[k]));
    end
    @(negedge Clock);
    checkOutput("pc_after_mvi", 32'(r[7]), 32'd2);
    checkOutput("r2_after_mvi", 32'(r[2]), 32'd5);

    $display("[TB] running program");
    applyStimulus(1'b0, 1'b1, 130);
    stopRun("prog");
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("R%0d", i), 32'(r[i]), 32'(exp_r[i]));
      checkOutput($sformatf("model_R%0d", i), 32'(m_r[i]), 32'(exp_r[i]));
    end
    checkOutput("mem_40", 32'(mem[7'h40]), 32'h0AB);
    checkOutput("G", 32'(g_q), 32'h00E);

    $display("[TB] reset during add E2");
    prog[0] = 9'h089;                       // add R1, R1
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 5);
    checkOutput("add_e2_gin", 32'(bus.Gin), 32'd1);
    checkOutput("add_e2_rout", 32'(bus.Rout), 32'h02);
    watch_gout = 1'b1;
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("reset_idle_done", 32'(bus.Done), 32'd0);
    checkOutput("reset_idle_word", 32'(dut_word), 32'd0);
    @(negedge Clock);
    watch_gout = 1'b0;
    checkOutput("gout_never", 32'(gout_seen), 32'd0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("restart_f1_rout", 32'(bus.Rout), 32'h80);
    checkOutput("restart_f1_addrin", 32'(bus.ADDRin), 32'd1);
    applyStimulus(1'b0, 1'b1, 40);
    stopRun("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
